// File: rtl/led_runner_pkg.sv
// led_runner_pkg: shared types for the LED runner.
//   mode_e : pattern mode as sampled from the mode port
//   dir_e  : travel direction of the bounce pattern
package led_runner_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'd0,
        MODE_ROR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step prescaler for the LED runner.
// Counts 0..STEP_CYC-1 and wraps; the count holds while i_pause is high.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset, clears the count
//   i_pause : freeze the count (also suppresses the tick)
//   o_tick  : high in the last cycle of a period when not paused
module led_tick_gen #(
    parameter int unsigned STEP_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pause,
    output logic o_tick
);

    localparam int unsigned CW = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(STEP_CYC - 1));
    // A pause asserted in the tick cycle wins: no tick, count stays at the end.
    assign o_tick = w_last && !i_pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_pause) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_runner.sv
// led_runner: LED pattern sequencer with optional PWM dimming.
// Optional feature macro: LED_RUNNER_PWM_EN (PWM gate on the LED outputs).
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   mode   : 0 rotate-left, 1 rotate-right, 2 bounce, 3 blink-all (sampled on tick)
//   pause  : freezes stepping while high
//   bright : PWM duty level (ignored unless LED_RUNNER_PWM_EN)
//   led    : registered LED drive
//   step   : one-cycle pulse on every pattern update
module led_runner
    import led_runner_pkg::*;
#(
    parameter int unsigned CLK_FRE  = 50,
    parameter int unsigned STEP_MS  = 1000,
    parameter int unsigned STEP_CYC = CLK_FRE * 1000 * STEP_MS,
    parameter int unsigned LED_NUM  = 4,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic                pause,
    input  logic [PWM_BITS-1:0] bright,
    output logic [LED_NUM-1:0]  led,
    output logic                step
);

    localparam logic [LED_NUM-1:0] PAT_INIT = {{(LED_NUM - 1){1'b0}}, 1'b1};

    logic               w_tick;
    mode_e              w_mode_in;
    mode_e              r_mode;
    mode_e              w_mode_d;
    dir_e               r_dir;
    dir_e               w_dir_d;
    logic [LED_NUM-1:0] r_pat;
    logic [LED_NUM-1:0] w_pat_d;
    logic               r_step;

    led_tick_gen #(
        .STEP_CYC (STEP_CYC)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pause (pause),
        .o_tick  (w_tick)
    );

    assign w_mode_in = mode_e'(mode);

    always_comb begin
        w_pat_d  = r_pat;
        w_mode_d = r_mode;
        w_dir_d  = r_dir;
        if (w_tick) begin
            if (w_mode_in != r_mode) begin
                // Mode switch reloads the start pattern instead of stepping.
                w_mode_d = w_mode_in;
                w_pat_d  = (w_mode_in == MODE_BLINK) ? '1 : PAT_INIT;
                w_dir_d  = DIR_UP;
            end else begin
                unique case (r_mode)
                    MODE_ROL:    w_pat_d = {r_pat[LED_NUM-2:0], r_pat[LED_NUM-1]};
                    MODE_ROR:    w_pat_d = {r_pat[0], r_pat[LED_NUM-1:1]};
                    MODE_BOUNCE: begin
                        // Direction flips on arrival at an end so the next tick
                        // leaves it immediately; no dwelling at either end.
                        if (r_dir == DIR_UP) begin
                            w_pat_d = r_pat << 1;
                            if (w_pat_d[LED_NUM-1]) w_dir_d = DIR_DOWN;
                        end else begin
                            w_pat_d = r_pat >> 1;
                            if (w_pat_d[0]) w_dir_d = DIR_UP;
                        end
                    end
                    MODE_BLINK:  w_pat_d = ~r_pat;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= PAT_INIT;
            r_mode <= MODE_ROL;
            r_dir  <= DIR_UP;
            r_step <= 1'b0;
        end else begin
            r_pat  <= w_pat_d;
            r_mode <= w_mode_d;
            r_dir  <= w_dir_d;
            r_step <= w_tick;
        end
    end

    assign step = r_step;

`ifdef LED_RUNNER_PWM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_gate;

    // Free-running; deliberately ignores pause so dimming never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    assign w_gate = (r_pwm_cnt < bright);
    assign led    = r_pat & {LED_NUM{w_gate}};
`else
    logic w_bright_unused;

    assign w_bright_unused = ^bright;
    assign led             = r_pat;
`endif

endmodule

// File: tb/tb_led_runner.sv
// tb_led_runner: randomized and directed checks of led_runner against a
// behavioural model (LED_NUM=4, STEP_CYC=4, PWM_BITS=4).
module tb_led_runner;

    localparam int N    = 4;
    localparam int SC   = 4;
    localparam int PB   = 4;
    localparam int MASK = (1 << N) - 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [1:0]    mode   = 2'd0;
    logic          pause  = 1'b0;
    logic [PB-1:0] bright = '1;
    logic [N-1:0]  led;
    logic          step;

    always #5 clk = ~clk;

    led_runner #(
        .STEP_CYC (SC),
        .LED_NUM  (N),
        .PWM_BITS (PB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode   (mode),
        .pause  (pause),
        .bright (bright),
        .led    (led),
        .step   (step)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: bounce position walks a ping-pong index 0..2(N-1)-1.
    int m_cnt, m_mode, m_pat, m_bk, m_step, m_pwm;

    function automatic int bounce_pat(input int k);
        int pos;
        pos = (k < N) ? k : 2 * (N - 1) - k;
        return 1 << pos;
    endfunction

    function automatic int exp_led();
`ifdef LED_RUNNER_PWM_EN
        return (m_pwm < int'(bright)) ? m_pat : 0;
`else
        return m_pat;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_pat = 1; m_bk = 0; m_step = 0; m_pwm = 0;
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic cycle();
        bit tick;
        tick = (m_cnt == SC - 1) && !pause;
        if (!pause) m_cnt = (m_cnt + 1) % SC;
        m_pwm = (m_pwm + 1) % (1 << PB);
        if (tick) begin
            if (int'(mode) != m_mode) begin
                m_mode = int'(mode);
                m_pat  = (m_mode == 3) ? MASK : 1;
                m_bk   = 0;
            end else begin
                case (m_mode)
                    0: m_pat = ((m_pat << 1) | (m_pat >> (N - 1))) & MASK;
                    1: m_pat = ((m_pat >> 1) | ((m_pat & 1) << (N - 1))) & MASK;
                    2: begin
                        m_bk  = (m_bk + 1) % (2 * (N - 1));
                        m_pat = bounce_pat(m_bk);
                    end
                    default: m_pat = m_pat ^ MASK;
                endcase
            end
        end
        m_step = tick ? 1 : 0;
        @(posedge clk);
        #1;
        check_eq("led", int'(led), exp_led());
        check_eq("step", int'(step), m_step);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_led", int'(led), exp_led());
        check_eq("arst_step", int'(step), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_collect(input int ncyc, output int seq[$]);
        seq = {};
        repeat (ncyc) begin
            cycle();
            if (step) seq.push_back(int'(led));
        end
    endtask

    task automatic check_seq(input string tag, input int seq[$], input int exp[$]);
        check_eq({tag, "_len"}, seq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < seq.size()) check_eq(tag, seq[i], exp[i]);
        end
    endtask

    initial begin
        int seq[$];
        model_reset();
        #12;
        check_eq("reset_led", int'(led), exp_led());
        check_eq("reset_step", int'(step), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Rotate-left from reset release: one advance every SC cycles.
        mode = 2'd0;
        run_collect(16, seq);
`ifndef LED_RUNNER_PWM_EN
        check_seq("rol_seq", seq, '{2, 4, 8, 1});
`endif

        // Bounce: reload then ping-pong without dwelling at the ends.
        async_reset();
        mode = 2'd2;
        run_collect(32, seq);
`ifndef LED_RUNNER_PWM_EN
        check_seq("bounce_seq", seq, '{1, 2, 4, 8, 4, 2, 1, 2});
`endif

        // Mode 0 -> 1 mid-period: reload, then rotate right.
        async_reset();
        mode = 2'd0;
        repeat (5) cycle();
        mode = 2'd1;
        run_collect(11, seq);
`ifndef LED_RUNNER_PWM_EN
        check_seq("ror_seq", seq, '{1, 8, 4});
`endif

        // Pause for 10 cycles at cnt=2; advance lands 2 cycles after release.
        async_reset();
        mode = 2'd0;
        repeat (2) cycle();
        pause = 1'b1;
        repeat (10) cycle();
        pause = 1'b0;
        cycle();
        check_eq("pause_rel1_step", int'(step), 0);
        cycle();
        check_eq("pause_rel2_step", int'(step), 1);
`ifndef LED_RUNNER_PWM_EN
        check_eq("pause_rel2_led", int'(led), 2);
`endif

        // Pause rising in the tick cycle suppresses the advance.
        async_reset();
        repeat (3) cycle();
        pause = 1'b1;
        cycle();
        check_eq("pause_tick_step", int'(step), 0);
        repeat (3) cycle();
        pause = 1'b0;
        cycle();
        check_eq("pause_tick_resume", int'(step), 1);

        // Blink-all, then reset mid-sequence.
        async_reset();
        mode = 2'd3;
        run_collect(12, seq);
`ifndef LED_RUNNER_PWM_EN
        check_seq("blink_seq", seq, '{15, 0, 15});
`endif
        repeat (2) cycle();
        async_reset();
        repeat (SC) cycle();

`ifdef LED_RUNNER_PWM_EN
        // Fixed dimming levels against the model.
        bright = 4'd4;
        repeat (40) cycle();
        bright = 4'd0;
        repeat (20) cycle();
`endif

        // Randomized mode / pause / bright traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(5) == 0) pause = ~pause;
            if ($urandom_range(15) == 0) bright = PB'($urandom);
            if ($urandom_range(199) == 0) async_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_runner.md
LED_RUNNER -- requirements
Module: led_runner

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning the clock frequency in MHz.
REQ-002 SHALL have parameter STEP_MS, default 1000, meaning the pattern step period in ms.
REQ-003 SHALL have parameter STEP_CYC, default CLK_FRE*1000*STEP_MS, meaning clocks per step; it may be overridden directly, minimum 2.
REQ-004 SHALL have parameter LED_NUM, default 4, meaning the LED count; minimum 2.
REQ-005 SHALL have parameter PWM_BITS, default 4, meaning the brightness resolution.
REQ-006 SHALL have port clk, input, 1 bit: the system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port mode, input, 2 bits: 0 rotate-left, 1 rotate-right, 2 bounce, 3 blink-all.
REQ-009 SHALL have port pause, input, 1 bit: freezes stepping while high.
REQ-010 SHALL have port bright, input, PWM_BITS bits: duty level.
REQ-011 SHALL have port led, output, LED_NUM bits: the registered LED drive.
REQ-012 SHALL have port step, output, 1 bit: a one-cycle pulse on each pattern advance.

Function
REQ-013 SHALL keep a step counter cnt running 0..STEP_CYC-1 that wraps to 0; cnt holds while pause=1.
REQ-014 SHALL assert the internal tick in the cycle where cnt==STEP_CYC-1 and pause=0; the pattern and step update on the next clock edge, giving 1-cycle latency.
REQ-015 SHALL sample mode only on tick; mode changes between ticks have no effect until the next tick.
REQ-016 SHALL, on a tick whose sampled mode differs from the current mode, load the pattern with bit0=1 (modes 0-2) or all-ones (mode 3), set direction to up, and not apply a normal step on that tick.
REQ-017 SHALL, in mode 0, rotate the pattern left by one per tick, MSB wrapping to bit0.
REQ-018 SHALL, in mode 1, rotate the pattern right by one per tick, bit0 wrapping to MSB.
REQ-019 SHALL, in mode 2, move a one-hot bit in the direction register; on reaching MSB the direction flips down and the next position is LED_NUM-2; on reaching bit0 the direction flips up. It SHALL never dwell two ticks at an end (LED_NUM=2 alternates 01,10).
REQ-020 SHALL, in mode 3, invert all pattern bits each tick.
REQ-021 SHALL make led equal the pattern, ANDed with the PWM gate when PWM is compiled in, registered.
REQ-022 SHALL assert step for exactly one cycle coincident with each pattern update, including mode-change reloads.
REQ-023 SHALL let a pause rising edge in the same cycle as tick win: no advance occurs and cnt holds at STEP_CYC-1.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously clear cnt, set pattern=1 (bit0 only), set current mode=0 and direction=up, clear step, and drive led to bit0 only (or to 0 if PWM is compiled in and bright=0).
REQ-025 SHALL restart the step period from cnt=0 when reset is released mid-operation; the first advance occurs STEP_CYC cycles after release.

Configuration
REQ-026 SHALL compile in PWM dimming when macro LED_RUNNER_PWM_EN is defined: a free-running PWM_BITS counter drives the gate, which is 1 when pwm_cnt<bright (bright=0 gives always off; all-ones gives (2^PWM_BITS-1)/2^PWM_BITS duty). The PWM counter is reset to 0 and is unaffected by pause.
REQ-027 SHALL, without LED_RUNNER_PWM_EN, keep the bright port present but ignored, with led equal to the pattern.

Structure
REQ-028 SHALL place the mode enum typedef (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_BLINK) and the direction typedef in package led_runner_pkg.
REQ-029 SHALL implement the prescaler (cnt, pause hold, tick) as the sub-module led_tick_gen with parameter STEP_CYC.

Verification (LED_NUM=4, STEP_CYC=4)
REQ-030 SHALL cover: reset release with mode=0 -> led 0001 to 0010 to 0100 to 1000 to 0001, one step every 4 cycles, each with a 1-cycle step pulse.
REQ-031 SHALL cover: mode=2 held -> led 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-032 SHALL cover: mode 0 to 1 change mid-period -> the next tick reloads 0001 with a step pulse, then 1000, 0100.
REQ-033 SHALL cover: pause high for 10 cycles at cnt=2 -> led and cnt frozen, then the advance occurs 2 cycles after pause falls.
REQ-034 SHALL cover: mode=3 -> led 1111 (reload), 0000, 1111; rst_n pulsed mid-sequence -> led 0001 asynchronously.
REQ-035 SHALL cover, with LED_RUNNER_PWM_EN and PWM_BITS=4: bright=4 -> each lit LED high for 4 of every 16 cycles; bright=0 -> led=0000.
